// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - 9-key synchronizer, debouncer and one-hot press pulse generator (optional BTN_ROLLOVER_EN)
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] raw_buttons,
    input  logic       enable,
    output logic [8:0] buttons,
    output logic       press_valid,
    output logic       multi_err
);

    localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_REL = 2'd0,
        S_IDLE     = 2'd1,
        S_HELD     = 2'd2
    } state_t;

    function automatic logic is_one_hot(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

    logic              run_q, run_d;
    logic [8:0]        sync0_q, sync0_d;
    logic [8:0]        sync1_q, sync1_d;
    logic [8:0][19:0]  cnt_q, cnt_d;
    logic [8:0]        stable_q, stable_d;
    state_t            state_q, state_d;
    logic [8:0]        buttons_q, buttons_d;
    logic              press_valid_q, press_valid_d;
    logic              multi_err_q, multi_err_d;
`ifdef BTN_ROLLOVER_EN
    logic [8:0]        stable_prev_q, stable_prev_d;
    logic [8:0]        rise;
    assign rise = stable_q & ~stable_prev_q;
`endif

    // Reset-release flag and key synchronizers; the synchronizers run freely so a
    // key held through reset is already visible when the FSM starts evaluating.
    always_comb begin
        run_d   = 1'b1;
        sync0_d = raw_buttons;
        sync1_d = sync0_q;
    end

    // Reset-release flag and synchronizer flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            sync0_q <= 9'd0;
            sync1_q <= 9'd0;
        end else begin
            run_q   <= run_d;
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
        end
    end

    // Per-key debounce: count while the synchronized level differs from stable
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
`ifdef BTN_ROLLOVER_EN
        stable_prev_d = stable_prev_q;
`endif
        if (run_q) begin
`ifdef BTN_ROLLOVER_EN
            stable_prev_d = stable_q;
`endif
            for (int i = 0; i < 9; i++) begin
                if (sync1_q[i] == stable_q[i]) begin
                    cnt_d[i] = 20'd0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync1_q[i];
                    cnt_d[i]    = 20'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 20'd1;
                end
            end
        end
    end

    // Debounce counter and stable register flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 9'd0;
`ifdef BTN_ROLLOVER_EN
            stable_prev_q <= 9'd0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
`ifdef BTN_ROLLOVER_EN
            stable_prev_q <= stable_prev_d;
`endif
        end
    end

    // Press FSM: next state and registered pulse outputs
    always_comb begin
        state_d       = state_q;
        buttons_d     = 9'd0;
        press_valid_d = 1'b0;
        multi_err_d   = 1'b0;
        if (run_q) begin
            case (state_q)
                S_WAIT_REL: begin
                    // Leave only once nothing is held or still in the synchronizer
                    if (stable_q == 9'd0 && sync0_q == 9'd0 && sync1_q == 9'd0) begin
                        state_d = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (enable && stable_q != 9'd0) begin
                        state_d = S_HELD;
                        if (is_one_hot(stable_q)) begin
                            buttons_d     = stable_q;
                            press_valid_d = 1'b1;
                        end else begin
                            multi_err_d = 1'b1;
                        end
                    end
                end
                S_HELD: begin
                    if (stable_q == 9'd0) begin
                        state_d = S_IDLE;
                    end
`ifdef BTN_ROLLOVER_EN
                    else if (enable && rise != 9'd0) begin
                        if (is_one_hot(rise)) begin
                            buttons_d     = rise;
                            press_valid_d = 1'b1;
                        end else begin
                            multi_err_d = 1'b1;
                        end
                    end
`endif
                end
                default: state_d = S_WAIT_REL;
            endcase
        end
    end

    // FSM state and output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_WAIT_REL;
            buttons_q     <= 9'd0;
            press_valid_q <= 1'b0;
            multi_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            buttons_q     <= buttons_d;
            press_valid_q <= press_valid_d;
            multi_err_q   <= multi_err_d;
        end
    end

    assign buttons     = buttons_q;
    assign press_valid = press_valid_q;
    assign multi_err   = multi_err_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard testbench for button_conditioner
module tb_button_conditioner;

    localparam int D   = 4;
    localparam int LAT = D + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] raw_buttons = 9'd0;
    logic       enable = 1'b0;
    logic [8:0] buttons;
    logic       press_valid;
    logic       multi_err;

    int cyc = 0;
    int check_cnt = 0;
    int pass_cnt = 0;

    typedef struct {
        int         at;
        logic [8:0] btn;
        logic       pv;
        logic       me;
    } exp_t;

    exp_t exp_q[$];

    button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_buttons (raw_buttons),
        .enable      (enable),
        .buttons     (buttons),
        .press_valid (press_valid),
        .multi_err   (multi_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every non-idle output cycle must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && (buttons !== 9'd0 || press_valid !== 1'b0 || multi_err !== 1'b0)) begin
            check_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_output cyc=%0d buttons=%h press_valid=%b multi_err=%b required all zero",
                         cyc, buttons, press_valid, multi_err);
            end else begin
                e = exp_q.pop_front();
                if (cyc !== e.at || buttons !== e.btn || press_valid !== e.pv || multi_err !== e.me)
                    $display("FAIL pulse cyc=%0d buttons=%h press_valid=%b multi_err=%b required cyc=%0d buttons=%h press_valid=%b multi_err=%b",
                             cyc, buttons, press_valid, multi_err, e.at, e.btn, e.pv, e.me);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_press(input int at, input logic [8:0] b);
        exp_t e;
        e.at = at; e.btn = b; e.pv = 1'b1; e.me = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_multi(input int at);
        exp_t e;
        e.at = at; e.btn = 9'd0; e.pv = 1'b0; e.me = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic drained(input string name);
        check_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s pending=%0d required 0 (first expected at cyc %0d)", name, exp_q.size(), exp_q[0].at);
            exp_q.delete();
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if (buttons !== 9'd0) $display("FAIL reset_buttons got %h required 000", buttons); else pass_cnt++;
        check_cnt++;
        if (press_valid !== 1'b0) $display("FAIL reset_press_valid got %b required 0", press_valid); else pass_cnt++;
        check_cnt++;
        if (multi_err !== 1'b0) $display("FAIL reset_multi_err got %b required 0", multi_err); else pass_cnt++;
        step(3);
        rst_n = 1'b1;
        enable = 1'b1;
        step(5);
        check_cnt++;
        if ({buttons, press_valid, multi_err} !== 11'd0)
            $display("FAIL post_reset_idle got %h required 000", {buttons, press_valid, multi_err});
        else
            pass_cnt++;
    endtask

    task automatic test_single_press;
        raw_buttons = 9'h010;
        push_press(cyc + LAT, 9'h010);
        step(20);
        raw_buttons = 9'h000;
        step(20);
        drained("single_press");
    endtask

    task automatic test_glitch;
        for (int i = 0; i < 5; i++) begin
            raw_buttons = 9'h001;
            step(2);
            raw_buttons = 9'h000;
            step(2);
        end
        step(10);
        drained("glitch");
    endtask

    task automatic test_multi;
        raw_buttons = 9'h003;
        push_multi(cyc + LAT);
        step(15);
        raw_buttons = 9'h000;
        step(20);
        raw_buttons = 9'h001;
        push_press(cyc + LAT, 9'h001);
        step(15);
        raw_buttons = 9'h000;
        step(20);
        drained("multi");
    endtask

    task automatic test_enable_late;
        enable = 1'b0;
        raw_buttons = 9'h100;
        step(20);
        enable = 1'b1;
        push_press(cyc + 1, 9'h100);
        step(15);
        raw_buttons = 9'h000;
        step(20);
        drained("enable_late");
    endtask

    task automatic test_enable_drop;
        raw_buttons = 9'h002;
        step(6);
        enable = 1'b0;
        step(4);
        enable = 1'b1;
        push_press(cyc + 1, 9'h002);
        step(10);
        raw_buttons = 9'h000;
        step(20);
        drained("enable_drop");
    endtask

    task automatic test_hold_through_reset;
        raw_buttons = 9'h004;
        step(1);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(30);
        drained("held_through_reset");
        raw_buttons = 9'h000;
        step(20);
        raw_buttons = 9'h004;
        push_press(cyc + LAT, 9'h004);
        step(15);
        raw_buttons = 9'h000;
        step(20);
        drained("press_after_reset");
    endtask

    task automatic test_reset_mid;
        raw_buttons = 9'h020;
        step(4);
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({buttons, press_valid, multi_err} !== 11'd0)
            $display("FAIL reset_mid_debounce got %h required 000", {buttons, press_valid, multi_err});
        else
            pass_cnt++;
        raw_buttons = 9'h000;
        step(2);
        rst_n = 1'b1;
        step(20);
        drained("reset_mid_debounce");

        raw_buttons = 9'h040;
        push_press(cyc + LAT, 9'h040);
        step(LAT);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({buttons, press_valid, multi_err} !== 11'd0)
            $display("FAIL reset_mid_pulse got %h required 000", {buttons, press_valid, multi_err});
        else
            pass_cnt++;
        raw_buttons = 9'h000;
        step(2);
        rst_n = 1'b1;
        step(20);
        drained("reset_mid_pulse");
    endtask

    task automatic test_back_to_back;
        logic [8:0] k;
        for (int i = 0; i < 4; i++) begin
            k = 9'd1 << $urandom_range(0, 8);
            raw_buttons = k;
            push_press(cyc + LAT, k);
            step(12);
            raw_buttons = 9'h000;
            step(10);
        end
        drained("back_to_back");
    endtask

    task automatic test_rollover;
        raw_buttons = 9'h001;
        push_press(cyc + LAT, 9'h001);
        step(15);
        raw_buttons = 9'h081;
`ifdef BTN_ROLLOVER_EN
        push_press(cyc + LAT, 9'h080);
`endif
        step(15);
        raw_buttons = 9'h000;
        step(20);
        drained("rollover");
    endtask

    initial begin
        test_reset;
        test_single_press;
        test_glitch;
        test_multi;
        test_enable_late;
        test_enable_drop;
        test_hold_through_reset;
        test_reset_mid;
        test_back_to_back;
        test_rollover;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
